// File: rtl/minmax_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : minmax_scan_ctrl
// Purpose : Scans COUNT signed operands with a shared comparator and reports
//           the min/max values with the index of their first occurrence.
// Option  : MINMAX_DUAL_CMP_EN - second comparator, 2 cycles per operand.
// Rev     : 1.0  initial release
// ============================================================================
module minmax_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             empty,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] max_idx
);

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_FIRST   = 3'd1;
  localparam logic [2:0] C_GET     = 3'd2;
  localparam logic [2:0] C_CMP_MIN = 3'd3;
  localparam logic [2:0] C_CMP_MAX = 3'd4;
  localparam logic [2:0] C_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             empty_q, empty_d;

  logic w_accept;
  logic w_last;
  logic w_lt_min;
  logic w_lt_max;

  // Signed a < b from the subtractor: sign of the difference corrected by overflow.
  function automatic logic signed_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    logic             ovf;
    diff = a - b;
    ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    return diff[WIDTH-1] ^ ovf;
  endfunction

  assign w_accept = in_valid & in_ready;
  assign w_last   = (remaining_q == CNT_W'(1));

`ifdef MINMAX_DUAL_CMP_EN
  assign w_lt_min = signed_lt(hold_q, min_q);
  assign w_lt_max = signed_lt(max_q, hold_q);
`else
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic             w_lt;

  // One comparator: operands swap roles between the min and max compare states.
  assign w_cmp_a  = (state_q == C_CMP_MAX) ? max_q  : hold_q;
  assign w_cmp_b  = (state_q == C_CMP_MAX) ? hold_q : min_q;
  assign w_lt     = signed_lt(w_cmp_a, w_cmp_b);
  assign w_lt_min = w_lt;
  assign w_lt_max = w_lt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      hold_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      min_idx_q   <= min_idx_d;
      max_idx_q   <= max_idx_d;
      hold_q      <= hold_d;
      min_q       <= min_d;
      max_q       <= max_d;
      empty_q     <= empty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:    if (start) state_d = (count == '0) ? C_DONE : C_FIRST;
      C_FIRST:   if (w_accept) state_d = w_last ? C_DONE : C_GET;
      C_GET:     if (w_accept) state_d = C_CMP_MIN;
`ifdef MINMAX_DUAL_CMP_EN
      C_CMP_MIN: state_d = w_last ? C_DONE : C_GET;
`else
      C_CMP_MIN: state_d = C_CMP_MAX;
      C_CMP_MAX: state_d = w_last ? C_DONE : C_GET;
`endif
      C_DONE:    state_d = C_IDLE;
      default:   state_d = C_IDLE;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    idx_d       = idx_q;
    min_idx_d   = min_idx_q;
    max_idx_d   = max_idx_q;
    hold_d      = hold_q;
    min_d       = min_q;
    max_d       = max_q;
    empty_d     = empty_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          remaining_d = count;
          idx_d       = '0;
          empty_d     = (count == '0);
          min_d       = '0;
          max_d       = '0;
          min_idx_d   = '0;
          max_idx_d   = '0;
        end
      end
      C_FIRST: begin
        if (w_accept) begin
          min_d       = in_data;
          max_d       = in_data;
          min_idx_d   = '0;
          max_idx_d   = '0;
          remaining_d = remaining_q - CNT_W'(1);
          idx_d       = CNT_W'(1);
        end
      end
      C_GET: begin
        if (w_accept) hold_d = in_data;
      end
      C_CMP_MIN: begin
        if (w_lt_min) begin
          min_d     = hold_q;
          min_idx_d = idx_q;
        end
`ifdef MINMAX_DUAL_CMP_EN
        if (w_lt_max) begin
          max_d     = hold_q;
          max_idx_d = idx_q;
        end
        idx_d       = idx_q + CNT_W'(1);
        remaining_d = remaining_q - CNT_W'(1);
`endif
      end
`ifndef MINMAX_DUAL_CMP_EN
      C_CMP_MAX: begin
        if (w_lt_max) begin
          max_d     = hold_q;
          max_idx_d = idx_q;
        end
        idx_d       = idx_q + CNT_W'(1);
        remaining_d = remaining_q - CNT_W'(1);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      C_IDLE:         busy      = 1'b0;
      C_FIRST, C_GET: in_ready  = 1'b1;
      C_DONE:         out_valid = 1'b1;
      default: ;
    endcase
  end

  assign empty   = empty_q;
  assign min_out = min_q;
  assign max_out = max_q;
  assign min_idx = min_idx_q;
  assign max_idx = max_idx_q;

endmodule
`default_nettype wire
